// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Iteration counter width; one bit minimum so a 1-wide counter still exists.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference only when it is non-negative.
module div_step #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic                  in_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_next,
  output logic                  q_bit
);

  localparam int unsigned N = DATA_WIDTH;

  logic [N:0] t;
  logic [N:0] d_ext;

  // rem < divisor holds between iterations, so its MSB is always 0 and only N bits shift up.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[N];

  // Trial subtraction at N+1 bits so the shifted value never overflows.
  always_comb begin
    t        = {rem[N-1:0], in_bit};
    d_ext    = {1'b0, divisor};
    q_bit    = (t >= d_ext);
    rem_next = q_bit ? (t - d_ext) : t;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned 2N/N restoring divider, one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero and quotient overflow are detected at acceptance and finish in one cycle.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] dividend_in,
  input  logic [DATA_WIDTH-1:0]   divisor_in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int unsigned N  = DATA_WIDTH;
  localparam int unsigned CW = cnt_width(N);

  div_state_t    state_q, state_d;
  logic [N:0]    rem_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  div_q;
  logic [CW-1:0] cnt_q;
  logic          dbz_q;
  logic          ovf_q;

  logic          dbz_chk;
  logic          ovf_chk;
  logic          err_chk;
  logic          last_iter;
  logic [N:0]    rem_next;
  logic          q_bit;

  // Error checks look at the raw inputs because they are judged on the accepting edge.
  always_comb begin
    dbz_chk   = (divisor_in == '0);
    ovf_chk   = (dividend_in[2*N-1:N] >= divisor_in);
    err_chk   = dbz_chk | ovf_chk;
    last_iter = (cnt_q == '0);
  end

  div_step #(
    .DATA_WIDTH(N)
  ) u_step (
    .rem     (rem_q),
    .in_bit  (q_q[N-1]),
    .divisor (div_q),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = err_chk ? DONE : RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand/result datapath. q_q doubles as the quotient and rem_q as the remainder, so results
  // hold after DONE until the next acceptance overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      q_q   <= '0;
      div_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q <= divisor_in;
            cnt_q <= CW'(N - 1);
            dbz_q <= dbz_chk;
            ovf_q <= ~dbz_chk & ovf_chk;
            if (err_chk) begin
              rem_q <= '0;
              q_q   <= '0;
            end else begin
              rem_q <= {1'b0, dividend_in[2*N-1:N]};
              q_q   <= dividend_in[N-1:0];
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          q_q   <= {q_q[N-2:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q_q;
  assign remainder   = rem_q[N-1:0];
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
